// File: rtl/tdd_cfg_sched.sv
// TDD configuration scheduler: round-robin intake of two pattern requesters,
// symbol-budget validation, and frame-aligned commit with a guard window.
module tdd_cfg_sched #(
   parameter int unsigned GUARD_CYC = 16
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        en,
   input  logic        tick_10ms,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [28:0] req0_cfg,
   input  logic [28:0] req1_cfg,
   output logic        tdd_valid,
   output logic [1:0]  tdd_mode,
   output logic [5:0]  dl_slt_num,
   output logic [3:0]  dl_sym_num,
   output logic [5:0]  ul_slt_num,
   output logic [3:0]  ul_sym_num,
   output logic [6:0]  trx_periodicity,
   output logic        cfg_err,
   output logic        err_src,
   output logic [1:0]  err_code,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_PEND, ST_GUARD} state_t;

   localparam logic [7:0] GUARD_INIT = 8'(GUARD_CYC);

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic [28:0] stage_q, stage_d;
   logic        stage_src_q, stage_src_d;
   logic [28:0] pat_q, pat_d;
   logic [7:0]  gcnt_q, gcnt_d;
   logic        active_ok_q, active_ok_d;
   logic        tick_d_q;
   logic        tdd_valid_q, tdd_valid_d;
   logic        cfg_err_q, cfg_err_d;
   logic        err_src_q, err_src_d;
   logic [1:0]  err_code_q, err_code_d;

   logic        gnt0, gnt1, tick_rise;
   logic [1:0]  chk_code;

   // Returns 00 on pass, else the reject reason in priority order.
   function automatic logic [1:0] check_word(input logic [5:0] dlt, input logic [3:0] dls,
                                             input logic [5:0] ult, input logic [3:0] uls,
                                             input logic [6:0] per);
      logic [8:0]  sym_total;
      logic [10:0] used;
      logic [1:0]  code;
      case (per)
         7'd25:   sym_total = 9'd70;
         7'd50:   sym_total = 9'd140;
         7'd100:  sym_total = 9'd280;
         default: sym_total = 9'd0;
      endcase
      used = 11'(dlt) * 11'd14 + 11'(ult) * 11'd14 + 11'(dls) + 11'(uls);
      if (sym_total == 9'd0)                    code = 2'b01;
      else if (dls > 4'd13 || uls > 4'd13)      code = 2'b10;
      else if (used > 11'(sym_total))           code = 2'b11;
      else                                      code = 2'b00;
      return code;
   endfunction

   // On a tie the requester not served last wins.
   assign gnt0      = req0_valid & (~req1_valid | ptr_q);
   assign gnt1      = req1_valid & (~req0_valid | ~ptr_q);
   assign tick_rise = tick_10ms & ~tick_d_q;
   assign chk_code  = check_word(stage_q[26:21], stage_q[20:17], stage_q[16:11],
                                 stage_q[10:7], stage_q[6:0]);

   always_ff @(posedge clk) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (gnt0 | gnt1) state_d = ST_CHECK;
         ST_CHECK: state_d = (chk_code != 2'b00) ? ST_IDLE : ST_PEND;
         ST_PEND:  if (tick_rise) state_d = ST_GUARD;
         ST_GUARD: if (gcnt_q <= 8'd1) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = i_rst_n & (state_q == ST_IDLE) & gnt0;
      req1_ready = i_rst_n & (state_q == ST_IDLE) & gnt1;
      busy       = i_rst_n & (state_q != ST_IDLE);
   end

   always_comb begin
      ptr_d       = ptr_q;
      stage_d     = stage_q;
      stage_src_d = stage_src_q;
      pat_d       = pat_q;
      gcnt_d      = gcnt_q;
      active_ok_d = active_ok_q;
      cfg_err_d   = 1'b0;
      err_src_d   = err_src_q;
      err_code_d  = err_code_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt0) begin
               stage_d     = req0_cfg;
               stage_src_d = 1'b0;
               ptr_d       = 1'b0;
            end else if (gnt1) begin
               stage_d     = req1_cfg;
               stage_src_d = 1'b1;
               ptr_d       = 1'b1;
            end
         end
         ST_CHECK: begin
            if (chk_code != 2'b00) begin
               cfg_err_d  = 1'b1;
               err_src_d  = stage_src_q;
               err_code_d = chk_code;
            end
         end
         ST_PEND: begin
            if (tick_rise) begin
               pat_d       = stage_q;
               gcnt_d      = GUARD_INIT;
               active_ok_d = 1'b1;
            end
         end
         ST_GUARD: gcnt_d = gcnt_q - 8'd1;
         default: ;
      endcase
      // Driven from next state so the enable drops with the new pattern.
      tdd_valid_d = en & active_ok_d & (state_d != ST_GUARD);
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         ptr_q       <= 1'b1;
         pat_q       <= '0;
         gcnt_q      <= '0;
         active_ok_q <= 1'b0;
         tick_d_q    <= 1'b0;
         tdd_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         err_src_q   <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         ptr_q       <= ptr_d;
         pat_q       <= pat_d;
         gcnt_q      <= gcnt_d;
         active_ok_q <= active_ok_d;
         tick_d_q    <= tick_10ms;
         tdd_valid_q <= tdd_valid_d;
         cfg_err_q   <= cfg_err_d;
         err_src_q   <= err_src_d;
         err_code_q  <= err_code_d;
      end
   end

   always_ff @(posedge clk) begin
      stage_q     <= stage_d;
      stage_src_q <= stage_src_d;
   end

   assign {tdd_mode, dl_slt_num, dl_sym_num, ul_slt_num, ul_sym_num, trx_periodicity} = pat_q;
   assign tdd_valid = tdd_valid_q;
   assign cfg_err   = cfg_err_q;
   assign err_src   = err_src_q;
   assign err_code  = err_code_q;

endmodule

// File: doc/tdd_cfg_sched.md
# tdd_cfg_sched

Configuration scheduler for the TDD pattern generator. Two requesters (host register bank and remote control link) each submit a full TDD pattern word. The block arbitrates between them round-robin and validates the symbol budget. It commits an accepted pattern to the generator-facing outputs only on a 10 ms frame boundary, holding `tdd_valid` low for a guard window so the generator restarts cleanly on the new pattern.

## Interface
- `GUARD_CYC`, default 16: number of cycles `tdd_valid` is held low after a commit; legal range 1..255.
- `clk` in 1: 122.88 MHz system clock; the only clock.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: global TDD enable; gates `tdd_valid` only.
- `tick_10ms` in 1: frame tick level from the timing block; the block detects rising edges internally.
- `req0_valid`, `req1_valid` in 1 each: a request is presented.
- `req0_ready`, `req1_ready` out 1 each: the request is accepted this cycle.
- `req0_cfg`, `req1_cfg` in 29 each: pattern word, packed as {tdd_mode[28:27], dl_slt_num[26:21], dl_sym_num[20:17], ul_slt_num[16:11], ul_sym_num[10:7], trx_periodicity[6:0]}.
- `tdd_valid` out 1: enable to the generator.
- `tdd_mode` out 2: active pattern field, to the generator.
- `dl_slt_num` out 6: active pattern field, to the generator.
- `dl_sym_num` out 4: active pattern field, to the generator.
- `ul_slt_num` out 6: active pattern field, to the generator.
- `ul_sym_num` out 4: active pattern field, to the generator.
- `trx_periodicity` out 7: active pattern field, to the generator.
- `cfg_err` out 1: one-cycle pulse when a request is rejected.
- `err_src` out 1: requester index of the last reject; held until the next reject.
- `err_code` out 2: reason for the last reject; held until the next reject.
- `busy` out 1: high in CHECK, PEND and GUARD.

## Operation
- **States:** IDLE, CHECK, PEND, GUARD.
- **IDLE:**
  - The grant is combinational. With both `valid` signals high, the requester that was *not* served last wins. The last-served pointer resets to 1, so `req0` wins the first tie.
  - Only the granted requester sees `ready` high; `ready` is 0 in every other state and while `i_rst_n=0`.
  - On `valid & ready` the word is captured into the staging register, the pointer is updated, and the state goes to CHECK.
- **CHECK (exactly one cycle):**
  - `sym_total` (9-bit) is 70 for periodicity 25, 140 for 50, 280 for 100.
  - `used` (11-bit, no truncation) = dl_slt_num*14 + ul_slt_num*14 + dl_sym_num + ul_sym_num.
  - Reject conditions in priority order:
    - periodicity not in {25, 50, 100} → `err_code` 01.
    - dl_sym_num > 13 or ul_sym_num > 13 → `err_code` 10.
    - `used` > `sym_total` → `err_code` 11.
  - Checks apply in every `tdd_mode`.
  - Reject: pulse `cfg_err`, load `err_src`/`err_code`, discard the staging word, return to IDLE.
  - Pass: go to PEND.
- **PEND:**
  - Waits for a tick rising edge, `tick_rise = tick_10ms & ~tick_d`.
  - On `tick_rise`: the staging word is copied to the pattern outputs, the guard counter is loaded with `GUARD_CYC`, and the state goes to GUARD.
  - New requests are stalled (`ready`=0) while in PEND.
- **GUARD:**
  - The counter decrements each cycle; on reaching 0 the state goes to IDLE.
  - The `active_ok` flag is set on the first commit.
- **Output enable:** `tdd_valid` = `en & active_ok & (state != GUARD)`, registered.
- **Tick in wrong state:** a tick edge arriving in IDLE or CHECK is not remembered. A word that reaches PEND commits on the *next* tick edge.
- **`en` low:** does not stall the FSM. Commits proceed and outputs update; only `tdd_valid` is forced 0.
- **Reset, including mid-operation:**
  - State returns to IDLE; staging is discarded; `active_ok`=0; pointer=1.
  - All outputs reset to 0: `tdd_valid`, every pattern field, `cfg_err`, `err_src`, `err_code`, `busy`, both `ready` signals.

## Timing
- **Handshake:** `ready` is combinational from state and valids. A transfer occurs at the clock edge where `valid & ready` is high. A requester must hold `valid` and `cfg` stable until accepted.
- **CHECK latency:** CHECK is the cycle after acceptance. `cfg_err` is high in the cycle after CHECK, for one cycle, together with the updated `err_src`/`err_code`. IDLE is re-entered in that same cycle, so a new acceptance can occur 2 cycles after the rejected one.
- **Tick edge detect:** uses one register, so `tick_rise` is visible in the cycle `tick_10ms` first reads high.
- **Commit timing:** pattern outputs change, and `tdd_valid` falls, in the cycle after `tick_rise`. `tdd_valid` stays 0 for exactly `GUARD_CYC` cycles, then returns to `en & active_ok`.
- **After commit:** IDLE, and therefore the next `ready`, resumes in the cycle `tdd_valid` reasserts.
- **Worst-case submit-to-commit:** one frame (1 228 800 cycles) plus 3 cycles.

## Test plan
- **Reset:** hold `i_rst_n`=0 with both valids high → `ready`=0 on both and all outputs 0. Release → `req0_ready`=1 in the first IDLE cycle.
- **Pass and commit:** `req0_cfg` {00, 3, 6, 1, 4, 50} (used 66 ≤ 140), with `GUARD_CYC`=16 and `en`=1.
  - CHECK passes and the state waits in PEND.
  - On a tick edge, outputs show the new word the next cycle.
  - `tdd_valid` is 0 for 16 cycles, then 1.
- **Tie arbitration:** both requesters valid continuously → accepts alternate 0, 1, 0, 1 across successive commits.
- **Rejects:**
  - periodicity 40 → `cfg_err` pulse, `err_code`=01.
  - `req1` with dl_sym_num=14 → `err_code`=10, `err_src`=1.
  - {00, 9, 0, 1, 0, 50} (used 140) passes; {00, 9, 1, 1, 0, 50} (used 141) → `err_code`=11.
  - In every reject case, the outputs are unchanged.
- **Tick in CHECK cycle:**
  - A word accepted so that the tick edge lands in CHECK commits on the following tick (about 1 228 800 cycles later), not the current one.
  - `ready`=0 throughout PEND.
- **Mid-operation events:**
  - Reset asserted in PEND → pending word is lost and `tdd_valid` stays 0 until a fresh commit.
  - `en`=0 during GUARD → commit still completes and `tdd_valid` remains 0 until `en`=1.
